// File: rtl/muldiv_engine.sv
// muldiv_engine: multi-cycle MULT/MULTU/DIV/DIVU unit for a pipelined core.
// The execute stage stalls while ok is low. Results land in registered HI/LO.
// Multiplication is single-cycle by default.
// Macro MULDIV_MULT_2STAGE_EN selects a two-stage registered multiplier:
// partial products are registered, then summed in the next cycle.
// Division is radix-2 restoring on operand magnitudes and takes 32 cycles.
module muldiv_engine (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        ok,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // The shared counter always terminates at 31. A multiply is therefore
   // preloaded so that it leaves MUL after one or two cycles.
`ifdef MULDIV_MULT_2STAGE_EN
   localparam logic [4:0] MUL_CNT_INIT = 5'd30;
`else
   localparam logic [4:0] MUL_CNT_INIT = 5'd31;
`endif

   // Magnitude of a value that is optionally two's-complement signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      mag32 = (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

   // Conditional two's-complement negation.
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
      neg_if = en ? (32'd0 - v) : v;
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_signed_s;
   logic        sa_s;
   logic        sb_s;
   logic [63:0] mul_prod_s;
   logic [31:0] dvs_mag_s;
   logic [32:0] shift_s;
   logic [32:0] trial_s;
   logic [31:0] rem_step_s;
   logic [31:0] quo_step_s;
   logic [31:0] div_hi_s;
   logic [31:0] div_lo_s;
   logic [31:0] res_hi_s;
   logic [31:0] res_lo_s;
   logic        ok_s;
   logic        busy_s;

   assign is_signed_s = ~op_q[0];
   assign sa_s        = is_signed_s & a_q[31];
   assign sb_s        = is_signed_s & b_q[31];

`ifdef MULDIV_MULT_2STAGE_EN
   logic [48:0] pp_lo_q, pp_lo_d;
   logic [47:0] pp_hi_q, pp_hi_d;

   // Stage 1 forms signed A times the low/high halves of B; stage 2 adds them.
   always_comb begin
      pp_lo_d    = {{17{sa_s}}, a_q} * {33'd0, b_q[15:0]};
      pp_hi_d    = {{16{sa_s}}, a_q} * {{32{sb_s}}, b_q[31:16]};
      mul_prod_s = {{15{pp_lo_q[48]}}, pp_lo_q} + {pp_hi_q, 16'd0};
   end

   // Partial-product stage registers, refreshed while multiplying.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pp_lo_q <= 49'd0;
         pp_hi_q <= 48'd0;
      end else if (state_q == ST_MUL) begin
         pp_lo_q <= pp_lo_d;
         pp_hi_q <= pp_hi_d;
      end else begin
         pp_lo_q <= pp_lo_q;
         pp_hi_q <= pp_hi_q;
      end
   end
`else
   logic [63:0] a_ext_s;
   logic [63:0] b_ext_s;

   // Single-cycle product: sign-extend both operands to 64 bits, keep low 64.
   always_comb begin
      a_ext_s    = {{32{sa_s}}, a_q};
      b_ext_s    = {{32{sb_s}}, b_q};
      mul_prod_s = a_ext_s * b_ext_s;
   end
`endif

   // One restoring-division step, plus final sign fix and divide-by-zero result.
   always_comb begin
      dvs_mag_s = mag32(b_q, is_signed_s);
      shift_s   = {rem_q, quo_q[31]};
      trial_s   = shift_s - {1'b0, dvs_mag_s};
      if (trial_s[32]) begin
         rem_step_s = shift_s[31:0];
         quo_step_s = {quo_q[30:0], 1'b0};
      end else begin
         rem_step_s = trial_s[31:0];
         quo_step_s = {quo_q[30:0], 1'b1};
      end
      if (b_q == 32'd0) begin
         div_lo_s = 32'hFFFF_FFFF;
         div_hi_s = a_q;
      end else begin
         div_lo_s = neg_if(quo_step_s, sa_s ^ sb_s);
         div_hi_s = neg_if(rem_step_s, sa_s);
      end
   end

   // Pick the result that is written into HI/LO on entry to DONE.
   always_comb begin
      if (op_q[1]) begin
         res_hi_s = div_hi_s;
         res_lo_s = div_lo_s;
      end else begin
         res_hi_s = mul_prod_s[63:32];
         res_lo_s = mul_prod_s[31:0];
      end
   end

   // Next-state and datapath update; flush wins over everything, including the DONE write.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_d  = op;
                  a_d   = a;
                  b_d   = b;
                  rem_d = 32'd0;
                  quo_d = mag32(a, ~op[0]);
                  if (op[1]) begin
                     state_d = ST_DIV;
                     cnt_d   = 5'd0;
                  end else begin
                     state_d = ST_MUL;
                     cnt_d   = MUL_CNT_INIT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL, ST_DIV: begin
               if (state_q == ST_DIV) begin
                  rem_d = rem_step_s;
                  quo_d = quo_step_s;
               end else begin
                  rem_d = rem_q;
                  quo_d = quo_q;
               end
               if (cnt_q == 5'd31) begin
                  state_d = ST_DONE;
                  hi_d    = res_hi_s;
                  lo_d    = res_lo_s;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      ok_s   = 1'b1;
      busy_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ok_s = ~start;
         end
         ST_MUL, ST_DIV: begin
            ok_s   = 1'b0;
            busy_s = 1'b1;
         end
         ST_DONE: begin
            ok_s = 1'b1;
         end
         default: begin
            ok_s = 1'b1;
         end
      endcase
   end

   // State, operand, divider and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign ok   = ok_s;
   assign busy = busy_s;

endmodule

// File: tb/tb_muldiv_engine.sv
// Self-checking bench for muldiv_engine: directed literal cases, flush and
// reset scenarios, then randomized traffic compared against an arithmetic model.
module tb_muldiv_engine;

`ifdef MULDIV_MULT_2STAGE_EN
   localparam int MUL_LAT = 3;
`else
   localparam int MUL_LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        ok;
   logic        busy;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   muldiv_engine dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .hi    (hi),
      .lo    (lo),
      .ok    (ok),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Reference arithmetic: returns {hi, lo}.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'd0: res = sx * sy;
         2'd1: res = {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else res = {x % y, x / y};
         end
      endcase
      return res;
   endfunction

   // Model: phase 0 = idle, 1 = working, 2 = result cycle.
   int          m_phase = 0;
   int          m_left  = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= 0;
         m_left  <= 0;
         m_hi    <= 32'd0;
         m_lo    <= 32'd0;
      end else if (flush) begin
         m_phase <= 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_phase <= 1;
               m_left  <= op[1] ? 32 : MUL_LAT - 1;
               {p_hi, p_lo} <= ref_result(op, a, b);
            end
            1: begin
               if (m_left == 1) begin
                  m_phase <= 2;
                  m_hi    <= p_hi;
                  m_lo    <= p_lo;
               end else begin
                  m_left <= m_left - 1;
               end
            end
            default: m_phase <= 0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            chk("model_ok",   ok,   (m_phase == 0) ? {63'd0, ~start} : {63'd0, m_phase == 2});
            chk("model_busy", busy, {63'd0, m_phase == 1});
            chk("model_hi",   hi,   {32'd0, m_hi});
            chk("model_lo",   lo,   {32'd0, m_lo});
         end
      end
   end

   // Issue a request in the current cycle and wait for ok, checking latency and result.
   task automatic go(input string name, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo,
                     input int e_lat);
      int n;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      #3;
      n = 1;
      while (!ok && n < 60) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk({name, "_lat"}, n, e_lat);
      chk({name, "_hi"}, hi, {32'd0, e_hi});
      chk({name, "_lo"}, lo, {32'd0, e_lo});
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input int e_lat);
      @(negedge clk);
      go(name, o, x, y, e_hi, e_lo, e_lat);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'd0;
      a     = 32'd0;
      b     = 32'd0;
      @(negedge clk);
      #3;
      chk("reset_hi", hi, 64'd0);
      chk("reset_lo", lo, 64'd0);
      chk("reset_busy", busy, 64'd0);
      chk("reset_ok", ok, 64'd1);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Hand-computed cases.
      run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
      run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("divu_100_7", 2'd3, 32'd100,      32'd7,        32'd2,         32'd14,        33);
      run_op("divu_by0",  2'd3, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 33);
      run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33);
      run_op("div_7_m2",  2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33);
      run_op("div_by0_s", 2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
      run_op("divu_prior", 2'd3, 32'hFEDC_BA9D, 32'h1234_5679, 32'h1234_5678, 32'h0000_000D, 33);

      // Flush while the divider counter is at 10.
      @(negedge clk);
      start = 1'b1;
      op    = 2'd2;
      a     = 32'd1000;
      b     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #3;
      chk("flush_ok", ok, 64'd1);
      chk("flush_busy", busy, 64'd0);
      chk("flush_hi", hi, 64'h1234_5678);
      chk("flush_lo", lo, 64'h0000_000D);
      go("after_flush", 2'd0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MUL_LAT);

      // Reset while the divider counter is at 20.
      @(negedge clk);
      start = 1'b1;
      op    = 2'd2;
      a     = 32'hFFFF_0000;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b1;
      #2;
      chk("rst_mid_hi", hi, 64'd0);
      chk("rst_mid_lo", lo, 64'd0);
      chk("rst_mid_busy", busy, 64'd0);
      chk("rst_mid_ok", ok, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #3;
         chk("no_done_after_reset", {busy, hi, lo}, 65'd0);
      end

      // Randomized traffic, including ignored starts and occasional flushes.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 39) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = pick();
         b     = pick();
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      repeat (40) @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
